// File: rtl/commit_unit.sv
// commit_unit: in-order retire controller between the ROB head and architectural state.
// Latency: register writes and branch/JALR retire in the same cycle; a store acks in the st_done cycle;
//   a mispredict raises flush one cycle after the branch retires, for exactly one cycle.
// Backpressure: commit_ack is the only retire handshake. The head is held while a store waits on st_done,
//   and no retire happens during the flush cycle.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   commit_*                 ROB head entry (valid, id, op, rd, value, pc, addr, prediction info)
//   commit_ack               retire-head strobe (combinational)
//   rf_we/waddr/wdata/rob_id register file write port and rename-table tag clear
//   st_req/addr/data/size    store request (level, held until st_done), st_done completion
//   flush, redirect_pc       one-cycle global flush and fetch restart PC
//   bp_update/pc/taken/target branch predictor training strobe and payload
//   retired_cnt              committed-instruction counter (wraps)
module commit_unit #(
  parameter int INST_BYTES      = 4,
  parameter int CNT_WIDTH       = 32,
  parameter int ROB_ID_WIDTH    = 4,
  parameter int ALU_OP_WIDTH    = 8,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int REG_WIDTH       = 32,
  parameter int INST_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       commit_valid,
  input  logic [ROB_ID_WIDTH-1:0]    commit_id,
  input  logic [ALU_OP_WIDTH-1:0]    commit_op,
  input  logic [REG_ADDR_WIDTH-1:0]  commit_rd,
  input  logic [REG_WIDTH-1:0]       commit_value,
  input  logic [INST_ADDR_WIDTH-1:0] commit_pc,
  input  logic [INST_ADDR_WIDTH-1:0] commit_addr,
  input  logic                       commit_pred,
  input  logic                       commit_outcome,
  input  logic [INST_ADDR_WIDTH-1:0] commit_pred_target,
  output logic                       commit_ack,
  output logic                       rf_we,
  output logic [REG_ADDR_WIDTH-1:0]  rf_waddr,
  output logic [REG_WIDTH-1:0]       rf_wdata,
  output logic [ROB_ID_WIDTH-1:0]    rf_rob_id,
  output logic                       st_req,
  output logic [INST_ADDR_WIDTH-1:0] st_addr,
  output logic [REG_WIDTH-1:0]       st_data,
  output logic [1:0]                 st_size,
  input  logic                       st_done,
  output logic                       flush,
  output logic [INST_ADDR_WIDTH-1:0] redirect_pc,
  output logic                       bp_update,
  output logic [INST_ADDR_WIDTH-1:0] bp_pc,
  output logic                       bp_taken,
  output logic [INST_ADDR_WIDTH-1:0] bp_target,
  output logic [CNT_WIDTH-1:0]       retired_cnt
);

  // Opcode encodings shared with the decode/execute stages.
  localparam logic [ALU_OP_WIDTH-1:0] OP_SB   = 8'h30;
  localparam logic [ALU_OP_WIDTH-1:0] OP_SH   = 8'h31;
  localparam logic [ALU_OP_WIDTH-1:0] OP_SW   = 8'h32;
  localparam logic [ALU_OP_WIDTH-1:0] OP_BEQ  = 8'h40;
  localparam logic [ALU_OP_WIDTH-1:0] OP_BNE  = 8'h41;
  localparam logic [ALU_OP_WIDTH-1:0] OP_BLT  = 8'h42;
  localparam logic [ALU_OP_WIDTH-1:0] OP_BGE  = 8'h43;
  localparam logic [ALU_OP_WIDTH-1:0] OP_BLTU = 8'h44;
  localparam logic [ALU_OP_WIDTH-1:0] OP_BGEU = 8'h45;
  localparam logic [ALU_OP_WIDTH-1:0] OP_JALR = 8'h51;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_STORE_WAIT = 2'd1,
    S_FLUSH      = 2'd2
  } state_t;

  state_t state, state_next;

  // Op class decode
  logic is_store, is_branch, is_jalr;
  logic [1:0] size_dec;

  always_comb begin
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jalr   = 1'b0;
    size_dec  = 2'b10;
    case (commit_op)
      OP_SB:   begin is_store = 1'b1; size_dec = 2'b00; end
      OP_SH:   begin is_store = 1'b1; size_dec = 2'b01; end
      OP_SW:   begin is_store = 1'b1; size_dec = 2'b10; end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: is_branch = 1'b1;
      OP_JALR: is_jalr = 1'b1;
      default: ;
    endcase
  end

  // Mispredict detection. JALR always counts as taken, so a predicted
  // not-taken JALR is wrong even if the predicted target happens to match.
  logic target_miss, mispredict, actual_taken;
  logic [INST_ADDR_WIDTH-1:0] redirect_next;

  always_comb begin
    target_miss  = (commit_pred_target != commit_addr);
    actual_taken = is_jalr | commit_outcome;
    mispredict   = 1'b0;
    if (is_branch)
      mispredict = (commit_pred != commit_outcome) | (commit_outcome & target_miss);
    else if (is_jalr)
      mispredict = target_miss | ~commit_pred;
    redirect_next = actual_taken ? commit_addr
                                 : commit_pc + INST_ADDR_WIDTH'(INST_BYTES);
  end

  // Next-state and strobe logic
  logic start_store, enter_flush;

  always_comb begin
    state_next  = state;
    commit_ack  = 1'b0;
    rf_we       = 1'b0;
    bp_update   = 1'b0;
    start_store = 1'b0;
    enter_flush = 1'b0;

    case (state)
      S_IDLE: begin
        if (commit_valid) begin
          if (is_store) begin
            start_store = 1'b1;
            state_next  = S_STORE_WAIT;
          end else begin
            commit_ack = 1'b1;
            // Branches have no destination; x0 writes are dropped.
            rf_we      = ~is_branch & (commit_rd != '0);
            if (is_branch | is_jalr) begin
              bp_update = 1'b1;
              if (mispredict) begin
                enter_flush = 1'b1;
                state_next  = S_FLUSH;
              end
            end
          end
        end
      end

      S_STORE_WAIT: begin
        if (st_done) begin
          // The store is done in memory regardless; only ack a present head.
          commit_ack = commit_valid;
          state_next = S_IDLE;
        end
      end

      S_FLUSH: begin
        // The head presented now is younger than the mispredict and is being squashed.
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase

    // Nothing retires in a reset cycle.
    if (rst) begin
      commit_ack  = 1'b0;
      rf_we       = 1'b0;
      bp_update   = 1'b0;
      start_store = 1'b0;
      enter_flush = 1'b0;
    end
  end

  // Pass-through payloads; qualified by their strobes.
  assign rf_waddr  = commit_rd;
  assign rf_wdata  = commit_value;
  assign rf_rob_id = commit_id;
  assign bp_pc     = commit_pc;
  assign bp_taken  = commit_outcome;
  assign bp_target = commit_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      st_req      <= 1'b0;
      st_addr     <= '0;
      st_data     <= '0;
      st_size     <= 2'b00;
      flush       <= 1'b0;
      redirect_pc <= '0;
      retired_cnt <= '0;
    end else begin
      state <= state_next;

      // Store payload is captured once so it stays stable while st_req is held.
      if (start_store) begin
        st_req  <= 1'b1;
        st_addr <= commit_addr;
        st_data <= commit_value;
        st_size <= size_dec;
      end else if (state == S_STORE_WAIT && st_done) begin
        st_req <= 1'b0;
      end

      flush <= enter_flush;
      if (enter_flush)
        redirect_pc <= redirect_next;

      if (commit_ack)
        retired_cnt <= retired_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_commit_unit.sv
// Directed testbench for commit_unit: register commits, store handshake,
// branch/JALR mispredict flush and reset during a pending store.
module tb_commit_unit;

  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_ADDI = 8'h02;
  localparam logic [7:0] OP_SB   = 8'h30;
  localparam logic [7:0] OP_SW   = 8'h32;
  localparam logic [7:0] OP_BEQ  = 8'h40;
  localparam logic [7:0] OP_BNE  = 8'h41;
  localparam logic [7:0] OP_BLT  = 8'h42;
  localparam logic [7:0] OP_JALR = 8'h51;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [3:0]  commit_id;
  logic [7:0]  commit_op;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [31:0] commit_pc;
  logic [31:0] commit_addr;
  logic        commit_pred;
  logic        commit_outcome;
  logic [31:0] commit_pred_target;
  logic        commit_ack;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  rf_rob_id;
  logic        st_req;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_done;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        bp_update;
  logic [31:0] bp_pc;
  logic        bp_taken;
  logic [31:0] bp_target;
  logic [31:0] retired_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  commit_unit dut (
    .clk                (clk),
    .rst                (rst),
    .commit_valid       (commit_valid),
    .commit_id          (commit_id),
    .commit_op          (commit_op),
    .commit_rd          (commit_rd),
    .commit_value       (commit_value),
    .commit_pc          (commit_pc),
    .commit_addr        (commit_addr),
    .commit_pred        (commit_pred),
    .commit_outcome     (commit_outcome),
    .commit_pred_target (commit_pred_target),
    .commit_ack         (commit_ack),
    .rf_we              (rf_we),
    .rf_waddr           (rf_waddr),
    .rf_wdata           (rf_wdata),
    .rf_rob_id          (rf_rob_id),
    .st_req             (st_req),
    .st_addr            (st_addr),
    .st_data            (st_data),
    .st_size            (st_size),
    .st_done            (st_done),
    .flush              (flush),
    .redirect_pc        (redirect_pc),
    .bp_update          (bp_update),
    .bp_pc              (bp_pc),
    .bp_taken           (bp_taken),
    .bp_target          (bp_target),
    .retired_cnt        (retired_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic head(input logic [7:0] op, input logic [4:0] rd, input logic [31:0] value,
                      input logic [3:0] id, input logic [31:0] pc, input logic [31:0] addr,
                      input logic pred, input logic outcome, input logic [31:0] ptarget);
    commit_valid       = 1'b1;
    commit_op          = op;
    commit_rd          = rd;
    commit_value       = value;
    commit_id          = id;
    commit_pc          = pc;
    commit_addr        = addr;
    commit_pred        = pred;
    commit_outcome     = outcome;
    commit_pred_target = ptarget;
  endtask

  task automatic no_head();
    commit_valid = 1'b0;
    commit_op    = OP_ADD;
    commit_rd    = 5'd0;
  endtask

  // Inputs change on the falling edge; checks run 1 time unit later.
  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    st_done = 1'b0;
    head(OP_ADD, 5'd0, 32'h0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    commit_valid = 1'b0;
    repeat (2) next();
    #1;
    chk("rst_ack", commit_ack, 0);
    chk("rst_st_req", st_req, 0);
    chk("rst_flush", flush, 0);
    chk("rst_bp_update", bp_update, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_redirect", redirect_pc, 0);
    chk("rst_cnt", retired_cnt, 0);

    // ADD x5 = 0x1234
    next(); rst = 1'b0;
    head(OP_ADD, 5'd5, 32'h1234, 4'd3, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("add_ack", commit_ack, 1);
    chk("add_we", rf_we, 1);
    chk("add_waddr", rf_waddr, 5);
    chk("add_wdata", rf_wdata, 32'h1234);
    chk("add_robid", rf_rob_id, 3);
    chk("add_bp", bp_update, 0);

    // ADDI x0: ack but no write
    next(); head(OP_ADDI, 5'd0, 32'h55, 4'd4, 32'h44, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("add_cnt", retired_cnt, 1);
    chk("x0_ack", commit_ack, 1);
    chk("x0_we", rf_we, 0);

    // Back-to-back register commits
    next(); head(OP_ADD, 5'd7, 32'h77, 4'd5, 32'h48, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("x0_cnt", retired_cnt, 2);
    chk("b2b0_ack", commit_ack, 1);
    chk("b2b0_waddr", rf_waddr, 7);
    next(); head(OP_ADD, 5'd8, 32'h88, 4'd6, 32'h4C, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("b2b0_cnt", retired_cnt, 3);
    chk("b2b1_ack", commit_ack, 1);
    chk("b2b1_wdata", rf_wdata, 32'h88);

    // SW 0xDEADBEEF -> 0x1000, st_done in the third st_req cycle
    next(); head(OP_SW, 5'd0, 32'hDEADBEEF, 4'd7, 32'h50, 32'h1000, 1'b0, 1'b0, 32'h0);
    #1;
    chk("b2b1_cnt", retired_cnt, 4);
    chk("sw_issue_ack", commit_ack, 0);
    chk("sw_issue_req", st_req, 0);
    chk("sw_issue_we", rf_we, 0);
    next(); commit_value = 32'h0; commit_addr = 32'h0;  // payload must already be captured
    #1;
    chk("sw_w1_req", st_req, 1);
    chk("sw_w1_addr", st_addr, 32'h1000);
    chk("sw_w1_data", st_data, 32'hDEADBEEF);
    chk("sw_w1_size", st_size, 2'b10);
    chk("sw_w1_ack", commit_ack, 0);
    next(); #1;
    chk("sw_w2_req", st_req, 1);
    chk("sw_w2_ack", commit_ack, 0);
    next(); st_done = 1'b1; #1;
    chk("sw_w3_req", st_req, 1);
    chk("sw_done_ack", commit_ack, 1);
    next(); st_done = 1'b0; no_head(); #1;
    chk("sw_after_req", st_req, 0);
    chk("sw_after_ack", commit_ack, 0);
    chk("sw_cnt", retired_cnt, 5);

    // Stray st_done in IDLE is ignored
    next(); st_done = 1'b1; #1;
    chk("stray_done_ack", commit_ack, 0);
    next(); st_done = 1'b0; #1;
    chk("stray_done_req", st_req, 0);
    chk("stray_done_cnt", retired_cnt, 5);

    // BEQ @0x80 predicted taken, actually not taken -> redirect 0x84
    next(); head(OP_BEQ, 5'd0, 32'h0, 4'd8, 32'h80, 32'h100, 1'b1, 1'b0, 32'h100);
    #1;
    chk("beq_ack", commit_ack, 1);
    chk("beq_bp", bp_update, 1);
    chk("beq_bp_pc", bp_pc, 32'h80);
    chk("beq_bp_taken", bp_taken, 0);
    chk("beq_bp_target", bp_target, 32'h100);
    chk("beq_we", rf_we, 0);
    chk("beq_flush_early", flush, 0);
    next(); head(OP_ADD, 5'd9, 32'h99, 4'd9, 32'h84, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("beq_flush", flush, 1);
    chk("beq_redirect", redirect_pc, 32'h84);
    chk("flush_ack", commit_ack, 0);
    chk("flush_we", rf_we, 0);
    chk("beq_cnt", retired_cnt, 6);
    next(); #1;
    chk("flush_end", flush, 0);
    chk("post_flush_ack", commit_ack, 1);

    // BNE correctly predicted taken: no flush
    next(); head(OP_BNE, 5'd0, 32'h0, 4'd10, 32'h90, 32'h180, 1'b1, 1'b1, 32'h180);
    #1;
    chk("post_flush_cnt", retired_cnt, 7);
    chk("bne_ack", commit_ack, 1);
    chk("bne_bp_taken", bp_taken, 1);
    next(); no_head(); #1;
    chk("bne_noflush", flush, 0);
    chk("bne_cnt", retired_cnt, 8);

    // BLT taken as predicted but to the wrong target
    next(); head(OP_BLT, 5'd0, 32'h0, 4'd11, 32'hA0, 32'h340, 1'b1, 1'b1, 32'h300);
    #1;
    chk("blt_ack", commit_ack, 1);
    next(); no_head(); #1;
    chk("blt_flush", flush, 1);
    chk("blt_redirect", redirect_pc, 32'h340);
    chk("blt_cnt", retired_cnt, 9);

    // JALR x1, link 0xB4, predicted 0x200, actual 0x240
    next(); head(OP_JALR, 5'd1, 32'hB4, 4'd12, 32'hB0, 32'h240, 1'b1, 1'b1, 32'h200);
    #1;
    chk("jalr_ack", commit_ack, 1);
    chk("jalr_we", rf_we, 1);
    chk("jalr_waddr", rf_waddr, 1);
    chk("jalr_wdata", rf_wdata, 32'hB4);
    chk("jalr_bp", bp_update, 1);
    chk("jalr_bp_target", bp_target, 32'h240);
    next(); no_head(); #1;
    chk("jalr_flush", flush, 1);
    chk("jalr_redirect", redirect_pc, 32'h240);
    chk("jalr_cnt", retired_cnt, 10);

    // Reset while a store is pending abandons it
    next(); head(OP_SW, 5'd0, 32'h11, 4'd13, 32'hC0, 32'h2000, 1'b0, 1'b0, 32'h0);
    #1;
    chk("sw2_issue_ack", commit_ack, 0);
    next(); #1;
    chk("sw2_req", st_req, 1);
    rst = 1'b1;
    next(); rst = 1'b0;
    head(OP_SB, 5'd0, 32'h22, 4'd14, 32'hC4, 32'h3000, 1'b0, 1'b0, 32'h0);
    st_done = 1'b1;
    #1;
    chk("rst_sw_req", st_req, 0);
    chk("rst_sw_done_ack", commit_ack, 0);
    chk("rst_sw_cnt", retired_cnt, 0);
    next(); #1;
    chk("sb_req", st_req, 1);
    chk("sb_addr", st_addr, 32'h3000);
    chk("sb_size", st_size, 2'b00);
    chk("sb_ack", commit_ack, 1);
    next(); st_done = 1'b0; no_head(); #1;
    chk("sb_req_clr", st_req, 0);
    chk("sb_cnt", retired_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
